// File: rtl/pong_score_keeper_pkg.sv
// Shared types and codes for the pong point/serve/match controller.
package pong_score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_GAME_OVER
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic DIR_TO_P1 = 1'b0;
  localparam logic DIR_TO_P2 = 1'b1;

endpackage

// File: rtl/pong_score_keeper_if.sv
// Game-event inputs and score/serve outputs of the pong score keeper.
interface pong_score_keeper_if #(
  parameter int SCORE_W = 4
) ();
  logic               start;
  logic               miss_p1;
  logic               miss_p2;
  logic [SCORE_W-1:0] sc1;
  logic [SCORE_W-1:0] sc2;
  logic               reset_game;
  logic               serve;
  logic               serve_dir;
  logic               game_over;
  logic [1:0]         winner;

  modport master (
    output start, miss_p1, miss_p2,
    input  sc1, sc2, reset_game, serve, serve_dir, game_over, winner
  );

  modport slave (
    input  start, miss_p1, miss_p2,
    output sc1, sc2, reset_game, serve, serve_dir, game_over, winner
  );
endinterface

// File: rtl/pong_score_keeper_serve_timer.sv
// Serve pacing counter: counts 0..SERVE_DLY-1 while enabled, then emits a registered done pulse.
module pong_serve_timer #(
  parameter int DLY_W     = 8,
  parameter int SERVE_DLY = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam logic [DLY_W-1:0] LAST = DLY_W'(SERVE_DLY - 1);

  logic [DLY_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  // done is registered, so it lands the cycle after the final count; ~done_q keeps it one cycle
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) done_d = ~done_q;
      else                 count_d = count_q + DLY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
endmodule

// File: rtl/pong_score_keeper.sv
// Point/serve/match controller: scores misses, applies win-by and cap rules, paces serves.
module pong_score_keeper
  import pong_score_keeper_pkg::*;
#(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 11,
  parameter int WIN_BY    = 2,
  parameter int SERVE_DLY = 50,
  parameter int DLY_W     = 8
) (
  input logic                sys_clock,
  input logic                reset,
  pong_score_keeper_if.slave bus
);
  if (WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
    $error("WIN_SCORE does not fit in SCORE_W bits");
  end
  if (SERVE_DLY < 1 || SERVE_DLY > (2 ** DLY_W) - 1) begin : g_bad_serve_dly
    $error("SERVE_DLY must be in 1..2**DLY_W-1");
  end

  localparam logic [SCORE_W-1:0]        WIN_SCORE_C = SCORE_W'(WIN_SCORE);
  localparam logic signed [SCORE_W:0]   WIN_BY_C    = (SCORE_W + 1)'(WIN_BY);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic               reset_game_q, reset_game_d;
  logic               serve_q, serve_d;
  logic               serve_dir_q, serve_dir_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] sc1_inc, sc2_inc;
  logic               timer_done;

  // A counter at full scale wins outright, so scores never need to wrap.
  function automatic logic win_test(input logic [SCORE_W-1:0] pts,
                                    input logic [SCORE_W-1:0] other);
    logic signed [SCORE_W:0] lead;
    lead = $signed({1'b0, pts}) - $signed({1'b0, other});
    return (pts == '1) || ((pts >= WIN_SCORE_C) && (lead >= WIN_BY_C));
  endfunction

  pong_serve_timer #(
    .DLY_W     (DLY_W),
    .SERVE_DLY (SERVE_DLY)
  ) u_serve_timer (
    .clk    (sys_clock),
    .rst    (reset),
    .clear  (state_q != ST_SERVE_WAIT),
    .enable (state_q == ST_SERVE_WAIT),
    .done   (timer_done)
  );

  assign sc1_inc = sc1_q + SCORE_W'(1);
  assign sc2_inc = sc2_q + SCORE_W'(1);

  always_comb begin
    state_d      = state_q;
    sc1_d        = sc1_q;
    sc2_d        = sc2_q;
    reset_game_d = 1'b0;
    serve_d      = 1'b0;
    serve_dir_d  = serve_dir_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          state_d      = ST_SERVE_WAIT;
          sc1_d        = '0;
          sc2_d        = '0;
          reset_game_d = 1'b1;
          serve_dir_d  = DIR_TO_P1;
          game_over_d  = 1'b0;
          winner_d     = WIN_NONE;
        end
      end
      ST_SERVE_WAIT: begin
        if (timer_done) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bus.miss_p1 && bus.miss_p2) begin
          state_d      = ST_SERVE_WAIT;
          reset_game_d = 1'b1;
        end else if (bus.miss_p1) begin
          sc2_d        = sc2_inc;
          reset_game_d = 1'b1;
          serve_dir_d  = DIR_TO_P1;
          if (win_test(sc2_inc, sc1_q)) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = WIN_P2;
          end else begin
            state_d = ST_SERVE_WAIT;
          end
        end else if (bus.miss_p2) begin
          sc1_d        = sc1_inc;
          reset_game_d = 1'b1;
          serve_dir_d  = DIR_TO_P2;
          if (win_test(sc1_inc, sc2_q)) begin
            state_d     = ST_GAME_OVER;
            game_over_d = 1'b1;
            winner_d    = WIN_P1;
          end else begin
            state_d = ST_SERVE_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sc1_q        <= '0;
      sc2_q        <= '0;
      reset_game_q <= 1'b0;
      serve_q      <= 1'b0;
      serve_dir_q  <= DIR_TO_P1;
      game_over_q  <= 1'b0;
      winner_q     <= WIN_NONE;
    end else begin
      state_q      <= state_d;
      sc1_q        <= sc1_d;
      sc2_q        <= sc2_d;
      reset_game_q <= reset_game_d;
      serve_q      <= serve_d;
      serve_dir_q  <= serve_dir_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign bus.sc1        = sc1_q;
  assign bus.sc2        = sc2_q;
  assign bus.reset_game = reset_game_q;
  assign bus.serve      = serve_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_pong_score_keeper.sv
// Randomized self-checking bench for pong_score_keeper against an integer scoring model.
module tb_pong_score_keeper;
  localparam int SCORE_W   = 4;
  localparam int WIN_SCORE = 11;
  localparam int WIN_BY    = 2;
  localparam int SERVE_DLY = 4;
  localparam int DLY_W     = 8;
  localparam int SC_MAX    = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst;

  pong_score_keeper_if #(.SCORE_W(SCORE_W)) bus ();

  pong_score_keeper #(
    .SCORE_W   (SCORE_W),
    .WIN_SCORE (WIN_SCORE),
    .WIN_BY    (WIN_BY),
    .SERVE_DLY (SERVE_DLY),
    .DLY_W     (DLY_W)
  ) dut (
    .sys_clock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int m_sc1, m_sc2, m_dir, m_win;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit m1, input bit m2);
    bus.start   = s;
    bus.miss_p1 = m1;
    bus.miss_p2 = m2;
    step();
    bus.start   = 1'b0;
    bus.miss_p1 = 1'b0;
    bus.miss_p2 = 1'b0;
  endtask

  // who: 1 = player 1 wins the point, 2 = player 2 wins it, 3 = both missed
  function automatic void model_point(input int who);
    if (who == 1) begin
      m_sc1 = m_sc1 + 1;
      m_dir = 1;
      if (m_sc1 == SC_MAX || (m_sc1 >= WIN_SCORE && m_sc1 - m_sc2 >= WIN_BY)) m_win = 1;
    end else if (who == 2) begin
      m_sc2 = m_sc2 + 1;
      m_dir = 0;
      if (m_sc2 == SC_MAX || (m_sc2 >= WIN_SCORE && m_sc2 - m_sc1 >= WIN_BY)) m_win = 2;
    end
  endfunction

  task automatic wait_serve(input bit noise, output int n);
    n = 0;
    do begin
      if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.miss_p1 = 1'($urandom_range(0, 1));
        bus.miss_p2 = 1'($urandom_range(0, 1));
      end
      step();
      n++;
    end while (bus.serve !== 1'b1 && n < 40);
    bus.start   = 1'b0;
    bus.miss_p1 = 1'b0;
    bus.miss_p2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_sc1 = 0; m_sc2 = 0; m_dir = 0; m_win = 0;
  endtask

  task automatic start_match();
    int n;
    m_sc1 = 0; m_sc2 = 0; m_dir = 0; m_win = 0;
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if (bus.reset_game !== 1'b1 || bus.serve_dir !== 1'b0) begin
      fails++;
      $display("FAIL start_pulse: reset_game=%0b serve_dir=%0b, want 1/0", bus.reset_game, bus.serve_dir);
    end
    tests++;
    if (bus.sc1 !== '0 || bus.sc2 !== '0 || bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
      fails++;
      $display("FAIL start_clear: sc=%0d/%0d go=%0b win=%0d, want 0/0 0 0",
               bus.sc1, bus.sc2, bus.game_over, bus.winner);
    end
    wait_serve(1'($urandom_range(0, 1)), n);
    tests++;
    if (n != SERVE_DLY + 1 || bus.serve_dir !== 1'b0) begin
      fails++;
      $display("FAIL start_serve: serve after %0d cycles dir=%0b, want %0d dir=0", n, bus.serve_dir, SERVE_DLY + 1);
    end
    step();
    tests++;
    if (bus.serve !== 1'b0) begin
      fails++;
      $display("FAIL serve_width: serve=%0b one cycle later, want 0", bus.serve);
    end
  endtask

  task automatic play_point(input int who, input bit noise);
    int idle, n;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tests++;
      if (bus.reset_game !== 1'b0 || bus.sc1 !== SCORE_W'(m_sc1) || bus.sc2 !== SCORE_W'(m_sc2)) begin
        fails++;
        $display("FAIL start_in_play: reset_game=%0b sc=%0d/%0d, want 0 %0d/%0d",
                 bus.reset_game, bus.sc1, bus.sc2, m_sc1, m_sc2);
      end
    end
    drive(1'b0, who != 1, who != 2);
    model_point(who);
    tests++;
    if (bus.sc1 !== SCORE_W'(m_sc1) || bus.sc2 !== SCORE_W'(m_sc2)) begin
      fails++;
      $display("FAIL point_score: who=%0d sc=%0d/%0d, want %0d/%0d", who, bus.sc1, bus.sc2, m_sc1, m_sc2);
    end
    tests++;
    if (bus.reset_game !== 1'b1 || bus.serve_dir !== 1'(m_dir)) begin
      fails++;
      $display("FAIL point_pulse: who=%0d reset_game=%0b dir=%0b, want 1 dir=%0d",
               who, bus.reset_game, bus.serve_dir, m_dir);
    end
    tests++;
    if (bus.game_over !== (m_win != 0) || bus.winner !== 2'(m_win)) begin
      fails++;
      $display("FAIL point_win: at %0d/%0d go=%0b winner=%0d, want %0b %0d",
               m_sc1, m_sc2, bus.game_over, bus.winner, m_win != 0, m_win);
    end
    if (m_win == 0) begin
      wait_serve(noise, n);
      tests++;
      if (n != SERVE_DLY + 1 || bus.serve_dir !== 1'(m_dir) ||
          bus.sc1 !== SCORE_W'(m_sc1) || bus.sc2 !== SCORE_W'(m_sc2)) begin
        fails++;
        $display("FAIL reserve: after %0d cycles dir=%0b sc=%0d/%0d, want %0d dir=%0d %0d/%0d",
                 n, bus.serve_dir, bus.sc1, bus.sc2, SERVE_DLY + 1, m_dir, m_sc1, m_sc2);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.miss_p1 = 1'b1; bus.miss_p2 = 1'b1;
    step();
    step();
    bus.start = 1'b0; bus.miss_p1 = 1'b0; bus.miss_p2 = 1'b0;
    tests++;
    if (bus.sc1 !== '0 || bus.sc2 !== '0 || bus.reset_game !== 1'b0 || bus.serve !== 1'b0 ||
        bus.serve_dir !== 1'b0 || bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: sc=%0d/%0d rg=%0b sv=%0b dir=%0b go=%0b win=%0d, want all 0",
               bus.sc1, bus.sc2, bus.reset_game, bus.serve, bus.serve_dir, bus.game_over, bus.winner);
    end
    rst = 1'b0;
    m_sc1 = 0; m_sc2 = 0; m_dir = 0; m_win = 0;
  endtask

  task automatic test_point_and_ignore();
    play_point(1, 1'b1);
    play_point(2, 1'b1);
    play_point(1, 1'b0);
  endtask

  task automatic test_double_miss();
    play_point(3, 1'b1);
    play_point(2, 1'b0);
    play_point(3, 1'b0);
  endtask

  task automatic test_game_over_hold();
    int sc1_w, sc2_w, win_w, pulses;
    sc1_w = m_sc1; sc2_w = m_sc2; win_w = m_win; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (bus.reset_game === 1'b1 || bus.serve === 1'b1) pulses++;
    end
    tests++;
    if (bus.sc1 !== SCORE_W'(sc1_w) || bus.sc2 !== SCORE_W'(sc2_w) || pulses != 0) begin
      fails++;
      $display("FAIL over_frozen: sc=%0d/%0d pulses=%0d, want %0d/%0d 0", bus.sc1, bus.sc2, pulses, sc1_w, sc2_w);
    end
    tests++;
    if (bus.game_over !== 1'b1 || bus.winner !== 2'(win_w)) begin
      fails++;
      $display("FAIL over_held: go=%0b winner=%0d, want 1 %0d", bus.game_over, bus.winner, win_w);
    end
  endtask

  task automatic test_deuce();
    do_reset();
    start_match();
    for (int i = 0; i < 10; i++) begin
      play_point(1, 1'($urandom_range(0, 1)));
      play_point(2, 1'($urandom_range(0, 1)));
    end
    play_point(1, 1'b0);
    tests++;
    if (bus.sc1 !== SCORE_W'(11) || bus.game_over !== 1'b0) begin
      fails++;
      $display("FAIL deuce_11_10: sc1=%0d go=%0b, want 11 0", bus.sc1, bus.game_over);
    end
    play_point(1, 1'b0);
    tests++;
    if (bus.sc1 !== SCORE_W'(12) || bus.game_over !== 1'b1 || bus.winner !== 2'b01) begin
      fails++;
      $display("FAIL deuce_12_10: sc1=%0d go=%0b winner=%0d, want 12 1 1", bus.sc1, bus.game_over, bus.winner);
    end
    test_game_over_hold();
    start_match();
  endtask

  task automatic test_cap();
    do_reset();
    start_match();
    for (int i = 0; i < 13; i++) begin
      play_point(1, 1'b0);
      play_point(2, 1'b0);
    end
    play_point(1, 1'b0);
    play_point(2, 1'b0);
    play_point(1, 1'b0);
    tests++;
    if (bus.sc1 !== SCORE_W'(15) || bus.sc2 !== SCORE_W'(14) || bus.winner !== 2'b01 || bus.game_over !== 1'b1) begin
      fails++;
      $display("FAIL cap_win: sc=%0d/%0d winner=%0d go=%0b, want 15/14 1 1",
               bus.sc1, bus.sc2, bus.winner, bus.game_over);
    end
    test_game_over_hold();
  endtask

  task automatic test_random_rallies();
    int r, guard;
    for (int g = 0; g < 3; g++) begin
      start_match();
      guard = 0;
      while (m_win == 0 && guard < 120) begin
        r = $urandom_range(0, 9);
        play_point(r < 4 ? 1 : (r < 8 ? 2 : 3), 1'($urandom_range(0, 1)));
        guard++;
      end
      tests++;
      if (bus.game_over !== 1'b1) begin
        fails++;
        $display("FAIL random_match_end: go=%0b after %0d points, want 1", bus.game_over, guard);
      end
      test_game_over_hold();
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_match();
    drive(1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_sc1 = 0; m_sc2 = 0; m_dir = 0; m_win = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.serve === 1'b1 || bus.reset_game === 1'b1) pulses++;
      step();
    end
    tests++;
    if (bus.sc1 !== '0 || bus.sc2 !== '0 || pulses != 0 || bus.serve_dir !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_wait: sc=%0d/%0d pulses=%0d dir=%0b, want 0/0 0 0",
               bus.sc1, bus.sc2, pulses, bus.serve_dir);
    end
    start_match();
    play_point(1, 1'b0);
    rst = 1'b1;
    bus.miss_p1 = 1'b1;
    step();
    rst = 1'b0;
    bus.miss_p1 = 1'b0;
    m_sc1 = 0; m_sc2 = 0; m_dir = 0; m_win = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.serve === 1'b1 || bus.reset_game === 1'b1) pulses++;
      step();
    end
    tests++;
    if (bus.sc1 !== '0 || bus.sc2 !== '0 || pulses != 0 || bus.game_over !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_play: sc=%0d/%0d pulses=%0d go=%0b, want 0/0 0 0",
               bus.sc1, bus.sc2, pulses, bus.game_over);
    end
    start_match();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.miss_p1 = 1'b0;
    bus.miss_p2 = 1'b0;
    step();
    test_reset();
    start_match();
    test_point_and_ignore();
    test_double_miss();
    test_deuce();
    test_cap();
    test_random_rallies();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached with %0d tests run, want completion", tests);
    $fatal(1, "simulation time limit");
  end
endmodule
